// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen -- raster timing generator for the VGA output path.
//
// Runs on the 25 MHz pixel clock. Two free-running counters (h_cnt, v_cnt)
// walk the raster. Every output is a registered decode of those counters, so
// all pins are mutually aligned and lag the counters by one cycle.
//
// Ports:
//   clk_in      in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   en          in   count enable; low freezes the raster and all outputs
//   hsync_n     out  horizontal sync, active low
//   vsync_n     out  vertical sync, active low (whole lines)
//   video_on    out  pixel is inside the visible area
//   pixel_x     out  column of the current pixel (0..H_TOTAL-1)
//   pixel_y     out  row of the current pixel (0..V_TOTAL-1)
//   line_start  out  one-cycle pulse at pixel_x==0
//   frame_start out  one-cycle pulse at pixel (0,0)
//   frame_cnt   out  frames completed, wraps 255->0
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CW        = 10
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          en,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Totals must fit in the counter width, otherwise the wrap point is
    // unreachable and the raster would run off the end.
    if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_bad_params
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 2**CW");
    end

    // Raster counters and the internal frame counter.
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]    frame_q, frame_d;

    // Registered outputs.
    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic          video_on_q, video_on_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    int h_int;
    int v_int;

    always_comb begin
        h_int = int'(h_cnt_q);
        v_int = int'(v_cnt_q);

        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_d       = frame_q;
        hsync_n_d     = hsync_n_q;
        vsync_n_d     = vsync_n_q;
        video_on_d    = video_on_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        frame_cnt_d   = frame_cnt_q;
        // Pulses never stretch across a frozen period.
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (en) begin
            hsync_n_d     = !((h_int >= HS_START) && (h_int < HS_END));
            vsync_n_d     = !((v_int >= VS_START) && (v_int < VS_END));
            video_on_d    = (h_int < H_VISIBLE) && (v_int < V_VISIBLE);
            pixel_x_d     = h_cnt_q;
            pixel_y_d     = v_cnt_q;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            // frame_q already counts the frame that just wrapped, so copying
            // it here lines frame_cnt up with the frame_start pulse.
            frame_cnt_d   = frame_q;

            // >= rather than == so an out-of-range value recovers at once.
            if (h_cnt_q >= H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q >= V_LAST) begin
                    v_cnt_d = '0;
                    frame_d = frame_q + 8'd1;
                end else begin
                    v_cnt_d = v_cnt_q + CNT_ONE;
                end
            end else begin
                h_cnt_d = h_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_q       <= '0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_q       <= frame_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
